// File: rtl/motor_drive_pwm_if.sv
// Command and drive-output bundle between the steering controller and the
// motor drive stage.
//   cmd_valid    : command qualifier, may stay high continuously
//   move_cmd     : W=0000, WA=0001, WD=0010, A=0100, D=0101, STOP=1000
//   speed_level  : turn magnitude 0..15
//   pwm_left/right, dir_left/right : H-bridge drive (dir 1=forward)
//   wdog_timeout : high while the watchdog-forced stop is active
//   at_target    : both wheel velocities equal their targets
// master = command source / output observer, slave = motor drive stage.
interface motor_drive_pwm_if;
    logic       cmd_valid;
    logic [3:0] move_cmd;
    logic [3:0] speed_level;
    logic       pwm_left;
    logic       pwm_right;
    logic       dir_left;
    logic       dir_right;
    logic       wdog_timeout;
    logic       at_target;

    modport master (
        output cmd_valid, move_cmd, speed_level,
        input  pwm_left, pwm_right, dir_left, dir_right, wdog_timeout, at_target
    );

    modport slave (
        input  cmd_valid, move_cmd, speed_level,
        output pwm_left, pwm_right, dir_left, dir_right, wdog_timeout, at_target
    );
endinterface

// File: rtl/motor_drive_pwm.sv
// Differential-drive motor stage: maps steering commands to signed per-wheel
// velocity targets, slew-limits each wheel toward its target, and produces
// glitch-free PWM plus direction for the H-bridge. A watchdog forces both
// targets to zero when commands stop arriving.
// Ports:
//   clk   : system clock
//   reset : synchronous, active-high reset
//   bus   : motor_drive_pwm_if.slave (command inputs, drive/status outputs)
// Wheel index 0 = left, 1 = right.
module motor_drive_pwm #(
    parameter int PWM_PERIOD  = 1000,
    parameter int DUTY_W      = 11,
    parameter int BASE_DUTY   = 600,
    parameter int TURN_GAIN   = 30,
    parameter int PIVOT_DUTY  = 450,
    parameter int RAMP_DIV    = 5000,
    parameter int RAMP_STEP   = 10,
    parameter int WDOG_CYCLES = 5000000
) (
    input  logic               clk,
    input  logic               reset,
    motor_drive_pwm_if.slave   bus
);
    localparam int VW  = DUTY_W + 1;
    localparam int RDW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int WDW = $clog2(WDOG_CYCLES + 1);

    localparam logic [3:0] CMD_W  = 4'b0000;
    localparam logic [3:0] CMD_WA = 4'b0001;
    localparam logic [3:0] CMD_WD = 4'b0010;
    localparam logic [3:0] CMD_A  = 4'b0100;
    localparam logic [3:0] CMD_D  = 4'b0101;
    localparam logic [3:0] CMD_STOP = 4'b1000;

    logic [3:0]        cmd_q, cmd_d;
    logic [3:0]        speed_q, speed_d;
    logic [RDW-1:0]    div_q, div_d;
    logic [WDW-1:0]    wdog_cnt_q, wdog_cnt_d;
    logic [DUTY_W-1:0] pwm_cnt_q, pwm_cnt_d;
    logic signed [VW-1:0] target_q [2];
    logic signed [VW-1:0] target_d [2];
    logic              at_target_q, at_target_d;
    logic              tick, wdog_hit, pwm_wrap;
    logic [1:0]        pwm_w, dir_w, on_target_w;
    int                turn_v, arc_lo_v, arc_hi_v, tgt_l_v, tgt_r_v;

    // Shared timing: command capture, ramp divider, watchdog, PWM counter.
    always_comb begin
        cmd_d   = cmd_q;
        speed_d = speed_q;
        if (bus.cmd_valid) begin
            cmd_d   = bus.move_cmd;
            speed_d = bus.speed_level;
        end

        tick  = (div_q == RDW'(RAMP_DIV - 1));
        div_d = tick ? '0 : div_q + 1'b1;

        wdog_hit = (wdog_cnt_q == WDW'(WDOG_CYCLES));
        if (bus.cmd_valid)
            wdog_cnt_d = '0;
        else if (wdog_hit)
            wdog_cnt_d = wdog_cnt_q;
        else
            wdog_cnt_d = wdog_cnt_q + 1'b1;

        pwm_wrap  = (pwm_cnt_q == DUTY_W'(PWM_PERIOD - 1));
        pwm_cnt_d = pwm_wrap ? '0 : pwm_cnt_q + 1'b1;
    end

    // Target mapping from the registered command. Forward arcs are clamped to
    // 0..PWM_PERIOD so a hard turn never reverses the inner wheel.
    always_comb begin
        turn_v   = int'(speed_q) * TURN_GAIN;
        arc_lo_v = BASE_DUTY - turn_v;
        arc_hi_v = BASE_DUTY + turn_v;
        if (arc_lo_v < 0)          arc_lo_v = 0;
        if (arc_lo_v > PWM_PERIOD) arc_lo_v = PWM_PERIOD;
        if (arc_hi_v < 0)          arc_hi_v = 0;
        if (arc_hi_v > PWM_PERIOD) arc_hi_v = PWM_PERIOD;

        tgt_l_v = 0;
        tgt_r_v = 0;
        case (cmd_q)
            CMD_W:  begin tgt_l_v = BASE_DUTY;   tgt_r_v = BASE_DUTY;   end
            CMD_WA: begin tgt_l_v = arc_lo_v;    tgt_r_v = arc_hi_v;    end
            CMD_WD: begin tgt_l_v = arc_hi_v;    tgt_r_v = arc_lo_v;    end
            CMD_A:  begin tgt_l_v = -PIVOT_DUTY; tgt_r_v = PIVOT_DUTY;  end
            CMD_D:  begin tgt_l_v = PIVOT_DUTY;  tgt_r_v = -PIVOT_DUTY; end
            default: begin tgt_l_v = 0;          tgt_r_v = 0;           end
        endcase
        if (wdog_hit) begin
            tgt_l_v = 0;
            tgt_r_v = 0;
        end
        target_d[0] = VW'(tgt_l_v);
        target_d[1] = VW'(tgt_r_v);
    end

    assign at_target_d = &on_target_w;

    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_q       <= CMD_STOP;
            speed_q     <= '0;
            div_q       <= '0;
            wdog_cnt_q  <= '0;
            pwm_cnt_q   <= '0;
            at_target_q <= 1'b1;
            for (int i = 0; i < 2; i++) target_q[i] <= '0;
        end else begin
            cmd_q       <= cmd_d;
            speed_q     <= speed_d;
            div_q       <= div_d;
            wdog_cnt_q  <= wdog_cnt_d;
            pwm_cnt_q   <= pwm_cnt_d;
            at_target_q <= at_target_d;
            for (int i = 0; i < 2; i++) target_q[i] <= target_d[i];
        end
    end

    // Per-wheel slew limiter, PWM compare and direction.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_wheel
            logic signed [VW-1:0] vel_q, vel_d;
            logic [DUTY_W-1:0]    mag_q, mag_d;
            logic                 pwm_q, pwm_d, dir_q, dir_d;
            int                   diff_v, nxt_v, abs_v;

            always_comb begin
                diff_v = int'(target_q[gi]) - int'(vel_q);
                nxt_v  = int'(vel_q);
                if (tick) begin
                    if (diff_v > RAMP_STEP)
                        nxt_v = nxt_v + RAMP_STEP;
                    else if (diff_v < -RAMP_STEP)
                        nxt_v = nxt_v - RAMP_STEP;
                    else
                        nxt_v = int'(target_q[gi]);
                    // A reversal must land on zero before changing sign.
                    if (vel_q > 0 && nxt_v < 0) nxt_v = 0;
                    if (vel_q < 0 && nxt_v > 0) nxt_v = 0;
                end
                vel_d = VW'(nxt_v);
                dir_d = (nxt_v >= 0);

                abs_v = (vel_q < 0) ? -int'(vel_q) : int'(vel_q);
                mag_d = pwm_wrap ? DUTY_W'(abs_v) : mag_q;
                // Compare against the next counter/magnitude so the registered
                // output always equals (counter < latched magnitude).
                pwm_d = (pwm_cnt_d < mag_d);
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    vel_q <= '0;
                    mag_q <= '0;
                    pwm_q <= 1'b0;
                    dir_q <= 1'b1;
                end else begin
                    vel_q <= vel_d;
                    mag_q <= mag_d;
                    pwm_q <= pwm_d;
                    dir_q <= dir_d;
                end
            end

            assign pwm_w[gi]       = pwm_q;
            assign dir_w[gi]       = dir_q;
            assign on_target_w[gi] = (vel_q == target_q[gi]);
        end
    endgenerate

    assign bus.pwm_left     = pwm_w[0];
    assign bus.pwm_right    = pwm_w[1];
    assign bus.dir_left     = dir_w[0];
    assign bus.dir_right    = dir_w[1];
    // A fresh command clears the timeout indication in the cycle it is sampled.
    assign bus.wdog_timeout = wdog_hit & ~bus.cmd_valid;
    assign bus.at_target    = at_target_q;
endmodule

// File: tb/tb_motor_drive_pwm.sv
module tb_motor_drive_pwm;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    motor_drive_pwm_if bus ();

    motor_drive_pwm #(
        .PWM_PERIOD (100),
        .DUTY_W     (7),
        .BASE_DUTY  (60),
        .TURN_GAIN  (5),
        .PIVOT_DUTY (40),
        .RAMP_DIV   (4),
        .RAMP_STEP  (10),
        .WDOG_CYCLES(1000)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Count high cycles of each PWM output over one 100-cycle window.
    task automatic count_duty(output int l, output int r);
        l = 0;
        r = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.pwm_left)  l++;
            if (bus.pwm_right) r++;
        end
    endtask

    task automatic send(input logic [3:0] cmd, input logic [3:0] lvl);
        bus.cmd_valid   = 1'b1;
        bus.move_cmd    = cmd;
        bus.speed_level = lvl;
    endtask

    task automatic check_duty(input string name, input int exp_l, input int exp_r);
        int l, r;
        count_duty(l, r);
        checks++;
        if (l !== exp_l) begin
            errors++;
            $display("FAIL %s left duty got %0d expected %0d", name, l, exp_l);
        end
        checks++;
        if (r !== exp_r) begin
            errors++;
            $display("FAIL %s right duty got %0d expected %0d", name, r, exp_r);
        end
        $display("%s: duty L=%0d R=%0d (expect %0d/%0d)", name, l, r, exp_l, exp_r);
    endtask

    task automatic check_dir(input string name, input logic exp_l, input logic exp_r);
        checks++;
        if ({bus.dir_left, bus.dir_right} !== {exp_l, exp_r}) begin
            errors++;
            $display("FAIL %s dir got %b%b expected %b%b", name,
                     bus.dir_left, bus.dir_right, exp_l, exp_r);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if ({bus.pwm_left, bus.pwm_right, bus.dir_left, bus.dir_right,
             bus.wdog_timeout, bus.at_target} !== 6'b001101) begin
            errors++;
            $display("FAIL %s outputs pwm/dir/wdog/at got %b%b%b%b%b%b expected 001101", name,
                     bus.pwm_left, bus.pwm_right, bus.dir_left, bus.dir_right,
                     bus.wdog_timeout, bus.at_target);
        end
        $display("%s: reset outputs checked", name);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        bus.cmd_valid   = 1'b0;
        bus.move_cmd    = 4'b1000;
        bus.speed_level = 4'd0;
        repeat (3) @(negedge clk);
        check_reset_outputs("test_reset");
        reset = 1'b0;
    endtask

    task automatic test_forward;
        int k;
        send(4'b0000, 4'd0);
        repeat (10) @(negedge clk);
        checks++;
        if (bus.at_target !== 1'b0) begin
            errors++;
            $display("FAIL fwd_midramp at_target got %b expected 0", bus.at_target);
        end
        k = 10;
        while (bus.at_target !== 1'b1 && k < 60) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (k < 22 || k > 27) begin
            errors++;
            $display("FAIL fwd_settle cycles got %0d expected 22..27", k);
        end
        $display("test_forward: at_target after %0d cycles", k);
        repeat (250) @(negedge clk);
        check_duty("test_forward", 60, 60);
        check_dir("test_forward", 1'b1, 1'b1);
    endtask

    task automatic test_arc;
        send(4'b0001, 4'd4);
        repeat (300) @(negedge clk);
        check_duty("test_arc_wa4", 40, 80);
        check_dir("test_arc_wa4", 1'b1, 1'b1);
        checks++;
        if (bus.at_target !== 1'b1) begin
            errors++;
            $display("FAIL arc_wa4 at_target got %b expected 1", bus.at_target);
        end
        send(4'b0010, 4'd15);
        repeat (300) @(negedge clk);
        check_duty("test_arc_wd15_sat", 100, 0);
        check_dir("test_arc_wd15_sat", 1'b1, 1'b1);
    endtask

    task automatic test_pivot;
        int k;
        send(4'b0000, 4'd0);
        repeat (300) @(negedge clk);
        send(4'b0100, 4'd0);
        k = 0;
        while (bus.dir_left !== 1'b0 && k < 80) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (k < 25 || k > 30) begin
            errors++;
            $display("FAIL pivot_dir_fall cycles got %0d expected 25..30", k);
        end
        $display("test_pivot: dir_left fell after %0d cycles", k);
        repeat (300) @(negedge clk);
        check_duty("test_pivot_a", 40, 40);
        check_dir("test_pivot_a", 1'b0, 1'b1);
        send(4'b0011, 4'd0);
        repeat (300) @(negedge clk);
        check_duty("test_pivot_unknown_cmd", 0, 0);
        check_dir("test_pivot_unknown_cmd", 1'b1, 1'b1);
    endtask

    task automatic test_watchdog;
        send(4'b0000, 4'd0);
        repeat (300) @(negedge clk);
        bus.cmd_valid = 1'b0;
        repeat (990) @(negedge clk);
        checks++;
        if (bus.wdog_timeout !== 1'b0) begin
            errors++;
            $display("FAIL wdog_early got %b expected 0", bus.wdog_timeout);
        end
        repeat (15) @(negedge clk);
        checks++;
        if (bus.wdog_timeout !== 1'b1) begin
            errors++;
            $display("FAIL wdog_fire got %b expected 1", bus.wdog_timeout);
        end
        repeat (300) @(negedge clk);
        check_duty("test_watchdog_stopped", 0, 0);
        checks++;
        if ({bus.wdog_timeout, bus.at_target} !== 2'b11) begin
            errors++;
            $display("FAIL wdog_stopped wdog/at got %b%b expected 11",
                     bus.wdog_timeout, bus.at_target);
        end
        send(4'b0000, 4'd0);
        #1;
        checks++;
        if (bus.wdog_timeout !== 1'b0) begin
            errors++;
            $display("FAIL wdog_clear_same_cycle got %b expected 0", bus.wdog_timeout);
        end
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        #1;
        checks++;
        if (bus.wdog_timeout !== 1'b0) begin
            errors++;
            $display("FAIL wdog_stay_clear got %b expected 0", bus.wdog_timeout);
        end
        repeat (300) @(negedge clk);
        check_duty("test_watchdog_recover", 60, 60);
    endtask

    task automatic test_reset_mid_ramp;
        int hi_early, hi_late;
        logic first_hi;
        send(4'b1000, 4'd0);
        repeat (300) @(negedge clk);
        send(4'b0000, 4'd0);
        repeat (13) @(negedge clk);
        checks++;
        if (bus.at_target !== 1'b0) begin
            errors++;
            $display("FAIL midramp at_target got %b expected 0", bus.at_target);
        end
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("test_reset_mid_ramp");
        reset = 1'b0;
        hi_early = 0;
        hi_late  = 0;
        first_hi = 1'b0;
        for (int k = 1; k < 200; k++) begin
            @(negedge clk);
            if (k < 100 && bus.pwm_left)  hi_early++;
            if (k >= 100 && bus.pwm_left) hi_late++;
            if (k == 100) first_hi = bus.pwm_left;
        end
        checks++;
        if (hi_early !== 0) begin
            errors++;
            $display("FAIL glitch_first_period high cycles got %0d expected 0", hi_early);
        end
        checks++;
        if (first_hi !== 1'b1) begin
            errors++;
            $display("FAIL glitch_wrap_edge pwm at counter 0 got %b expected 1", first_hi);
        end
        checks++;
        if (hi_late !== 60) begin
            errors++;
            $display("FAIL glitch_second_period high cycles got %0d expected 60", hi_late);
        end
        $display("test_reset_mid_ramp: early=%0d late=%0d", hi_early, hi_late);
    endtask

    initial begin
        test_reset;
        test_forward;
        test_arc;
        test_pivot;
        test_watchdog;
        test_reset_mid_ramp;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
